// File: rtl/inert_spi_seq.sv
`timescale 1ns/1ps
// SPI inertial-sensor sequencer: power-up settle, four init writes, then an
// INT-triggered four-byte read of pitch rate and Z acceleration.
module inert_spi_seq #(
  parameter logic [15:0] INIT_CYCLES = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic        vld,
  output logic [15:0] ptch_rt,
  output logic [15:0] AZ
);
  // state    | meaning
  // WAIT_PWR | settle counter running, no SPI traffic
  // INIT1..4 | init write n in flight, waiting for done
  // IDLE     | waiting for synchronized INT
  // RD_PL/PH | reading pitch-rate low / high byte
  // RD_AL/AH | reading Z-accel low / high byte
  // DONE     | sample complete, vld high
  typedef enum logic [3:0] {
    WAIT_PWR, INIT1, INIT2, INIT3, INIT4, IDLE,
    RD_PL, RD_PH, RD_AL, RD_AH, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cmd_q, cmd_d;
  logic        wrt_q, wrt_d;
  logic        vld_q, vld_d;
  logic        int_ff1_q, int_ff1_d;
  logic        int_ff2_q, int_ff2_d;
  logic [7:0]  ptch_lo_q, ptch_lo_d, ptch_hi_q, ptch_hi_d;
  logic [7:0]  az_lo_q, az_lo_d, az_hi_q, az_hi_d;
  logic        cnt_tc;
  logic        unused_rd_hi;

  assign cnt_tc       = (cnt_q == INIT_CYCLES);
  assign unused_rd_hi = ^rd_data[15:8];

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= WAIT_PWR;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_PWR: if (cnt_tc) state_d = INIT1;
      INIT1:    if (done) state_d = INIT2;
      INIT2:    if (done) state_d = INIT3;
      INIT3:    if (done) state_d = INIT4;
      INIT4:    if (done) state_d = IDLE;
      IDLE:     if (int_ff2_q) state_d = RD_PL;
      RD_PL:    if (done) state_d = RD_PH;
      RD_PH:    if (done) state_d = RD_AL;
      RD_AL:    if (done) state_d = RD_AH;
      RD_AH:    if (done) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = WAIT_PWR;
    endcase
  end

  // Strobes and the command are computed one cycle ahead and registered.
  always_comb begin
    cnt_d     = cnt_q;
    wrt_d     = 1'b0;
    cmd_d     = cmd_q;
    vld_d     = 1'b0;
    int_ff1_d = INT;
    int_ff2_d = int_ff1_q;
    ptch_lo_d = ptch_lo_q;
    ptch_hi_d = ptch_hi_q;
    az_lo_d   = az_lo_q;
    az_hi_d   = az_hi_q;
    case (state_q)
      WAIT_PWR: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_tc) begin
          wrt_d = 1'b1;
          cmd_d = 16'h0D02;
        end
      end
      INIT1: if (done) begin wrt_d = 1'b1; cmd_d = 16'h1053; end
      INIT2: if (done) begin wrt_d = 1'b1; cmd_d = 16'h1150; end
      INIT3: if (done) begin wrt_d = 1'b1; cmd_d = 16'h1460; end
      IDLE:  if (int_ff2_q) begin wrt_d = 1'b1; cmd_d = 16'hA200; end
      RD_PL: if (done) begin
        ptch_lo_d = rd_data[7:0];
        wrt_d     = 1'b1;
        cmd_d     = 16'hA300;
      end
      RD_PH: if (done) begin
        ptch_hi_d = rd_data[7:0];
        wrt_d     = 1'b1;
        cmd_d     = 16'hAC00;
      end
      RD_AL: if (done) begin
        az_lo_d = rd_data[7:0];
        wrt_d   = 1'b1;
        cmd_d   = 16'hAD00;
      end
      RD_AH: if (done) begin
        az_hi_d = rd_data[7:0];
        vld_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= 16'h0000;
      cmd_q     <= 16'h0000;
      wrt_q     <= 1'b0;
      vld_q     <= 1'b0;
      int_ff1_q <= 1'b0;
      int_ff2_q <= 1'b0;
      ptch_lo_q <= 8'h00;
      ptch_hi_q <= 8'h00;
      az_lo_q   <= 8'h00;
      az_hi_q   <= 8'h00;
    end else begin
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      wrt_q     <= wrt_d;
      vld_q     <= vld_d;
      int_ff1_q <= int_ff1_d;
      int_ff2_q <= int_ff2_d;
      ptch_lo_q <= ptch_lo_d;
      ptch_hi_q <= ptch_hi_d;
      az_lo_q   <= az_lo_d;
      az_hi_q   <= az_hi_d;
    end
  end

  assign wrt     = wrt_q;
  assign cmd     = cmd_q;
  assign vld     = vld_q;
  assign ptch_rt = {ptch_hi_q, ptch_lo_q};
  assign AZ      = {az_hi_q, az_lo_q};

endmodule
